// File: rtl/relu_pkg.sv
// Shared types for the activation stream unit.
//   act_mode_t    : per-frame activation function select
//   frame_state_t : frame tracking FSM state
package relu_pkg;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } frame_state_t;

endpackage

// File: rtl/relu_lane.sv
// Combinational activation function for one signed lane.
// Ports:
//   mode : activation select (act_mode_t encoding)
//   x    : signed input lane
//   y    : activated lane, same width; no result can overflow the lane
module relu_lane
  import relu_pkg::*;
#(
  parameter int bitwidth  = 8,
  parameter int leakShift = 3,
  parameter int clipMax   = 96
) (
  input  logic [1:0]                 mode,
  input  logic signed [bitwidth-1:0] x,
  output logic signed [bitwidth-1:0] y
);

  localparam logic signed [bitwidth-1:0] CLIP_V = bitwidth'(clipMax);

  logic neg;
  assign neg = x[bitwidth-1];

  always_comb begin
    y = x;
    case (act_mode_t'(mode))
      ACT_PASS:  y = x;
      ACT_RELU:  y = neg ? '0 : x;
      // arithmetic shift floors toward -inf, so -1 stays -1
      ACT_LEAKY: y = neg ? (x >>> leakShift) : x;
      ACT_CLIP: begin
        if (neg)             y = '0;
        else if (x > CLIP_V) y = CLIP_V;
        else                 y = x;
      end
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/relu_stream_unit.sv
// Activation stage for the CNN datapath: applies PASS/RELU/LEAKY/CLIP to
// `channels` signed lanes per beat with valid/ready flow control, counts
// beats per frame (imageWidth^2) and tags the last beat of each frame.
// Ports:
//   clock, reset  : rising-edge clock, async active-high reset
//   mode_in       : activation mode, sampled on the first beat of a frame
//   data_in       : lane k at [k*bitwidth +: bitwidth]
//   isValid_in    : upstream beat valid
//   isReady_out   : skid register empty (registered, no comb path from isReady_in)
//   data_out      : activated lanes, same packing
//   isValid_out   : output beat valid
//   isReady_in    : downstream accepts
//   isLast_out    : last beat of the frame, qualifies data_out
//   busy_out      : frame in progress
module relu_stream_unit
  import relu_pkg::*;
#(
  parameter int bitwidth   = 8,
  parameter int channels   = 1,
  parameter int imageWidth = 11,
  parameter int leakShift  = 3,
  parameter int clipMax    = 96
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   mode_in,
  input  logic [channels*bitwidth-1:0] data_in,
  input  logic                         isValid_in,
  output logic                         isReady_out,
  output logic [channels*bitwidth-1:0] data_out,
  output logic                         isValid_out,
  input  logic                         isReady_in,
  output logic                         isLast_out,
  output logic                         busy_out
);

  localparam int FRAME = imageWidth * imageWidth;
  localparam int CW    = $clog2(FRAME + 1);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

  frame_state_t state;
  logic [CW-1:0] cnt;
  act_mode_t     mode_q;

  logic                              skid_vld;
  logic [channels*bitwidth-1:0]      skid_data;
  logic                              skid_last;

  act_mode_t                         mode_eff;
  logic [channels-1:0][bitwidth-1:0] lane_y;
  logic                              accept;
  logic                              out_free;
  logic                              beat_last;

  // First beat of a frame uses the live mode; later beats use the latch.
  assign mode_eff    = (state == ST_IDLE) ? act_mode_t'(mode_in) : mode_q;
  assign isReady_out = ~skid_vld;
  assign accept      = isValid_in & isReady_out;
  assign out_free    = ~isValid_out | isReady_in;
  assign beat_last   = (state == ST_IDLE) ? (FRAME == 1) : ((cnt + 1'b1) == FRAME_C);

  for (genvar k = 0; k < channels; k++) begin : g_lane
    relu_lane #(
      .bitwidth (bitwidth),
      .leakShift(leakShift),
      .clipMax  (clipMax)
    ) u_lane (
      .mode(mode_eff),
      .x   (data_in[k*bitwidth +: bitwidth]),
      .y   (lane_y[k])
    );
  end

  // Frame FSM, advanced only by accepted beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mode_q   <= ACT_PASS;
      busy_out <= 1'b0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          mode_q <= act_mode_t'(mode_in);
          if (FRAME == 1) begin
            cnt <= '0;
          end else begin
            cnt      <= CW'(1);
            state    <= ST_RUN;
            busy_out <= 1'b1;
          end
        end
        ST_RUN: begin
          if (beat_last) begin
            cnt      <= '0;
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register plus one skid slot. Accept is only possible with the
  // skid empty, so a skid drain and an accept never collide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      isValid_out <= 1'b0;
      data_out    <= '0;
      isLast_out  <= 1'b0;
      skid_vld    <= 1'b0;
      skid_data   <= '0;
      skid_last   <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        isValid_out <= 1'b1;
        data_out    <= skid_data;
        isLast_out  <= skid_last;
        skid_vld    <= 1'b0;
      end else if (accept) begin
        isValid_out <= 1'b1;
        data_out    <= lane_y;
        isLast_out  <= beat_last;
      end else begin
        isValid_out <= 1'b0;
      end
    end else if (accept) begin
      skid_vld  <= 1'b1;
      skid_data <= lane_y;
      skid_last <= beat_last;
    end
  end

endmodule

// File: tb/tb_relu_stream_unit.sv
module tb_relu_stream_unit;

  localparam int BW = 8;
  localparam int CH = 2;
  localparam int IW = 2;
  localparam int FRAME = IW * IW;

  logic          clk;
  logic          rst;
  logic [1:0]    mode_in;
  logic [15:0]   data_in;
  logic          isValid_in;
  logic          isReady_out;
  logic [15:0]   data_out;
  logic          isValid_out;
  logic          isReady_in;
  logic          isLast_out;
  logic          busy_out;

  relu_stream_unit #(
    .bitwidth  (BW),
    .channels  (CH),
    .imageWidth(IW),
    .leakShift (3),
    .clipMax   (96)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .mode_in    (mode_in),
    .data_in    (data_in),
    .isValid_in (isValid_in),
    .isReady_out(isReady_out),
    .data_out   (data_out),
    .isValid_out(isValid_out),
    .isReady_in (isReady_in),
    .isLast_out (isLast_out),
    .busy_out   (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [16:0] exp_q[$];
  int fc = 0;
  int mode_lat = 0;
  int n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_beat(input int m, input logic [15:0] d);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      int x;
      int y;
      x = $signed(d[k*8 +: 8]);
      case (m)
        0: y = x;
        1: y = (x < 0) ? 0 : x;
        2: y = (x < 0) ? -((-x + 7) / 8) : x;   // floor(x/8)
        default: y = (x < 0) ? 0 : ((x > 96) ? 96 : x);
      endcase
      r[k*8 +: 8] = y[7:0];
    end
    return r;
  endfunction

  // Evaluated at negedge+1: inputs for the coming edge are set and outputs
  // reflect the previous edge, so this predicts exactly what the edge does.
  task automatic model_step();
    logic [16:0] e;
    if (rst) return;
    if ($isunknown({isValid_out, isReady_out, busy_out, isLast_out, data_out}))
      chk("x_on_out", 1, 0);
    if (isValid_out && isReady_in) begin
      if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat_data", {16'h0, data_out}, {16'h0, e[15:0]});
        chk("beat_last", {31'h0, isLast_out}, {31'h0, e[16]});
      end
    end
    if (isValid_in && isReady_out) begin
      if (fc == 0) mode_lat = int'(mode_in);
      exp_q.push_back({(fc == FRAME - 1), ref_beat(mode_lat, data_in)});
      fc = (fc + 1) % FRAME;
      n_acc++;
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] m, input logic [15:0] d, input logic r);
    @(negedge clk);
    isValid_in = v;
    mode_in    = m;
    data_in    = d;
    isReady_in = r;
    #1;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    isValid_in = 1'b0;
    isReady_in = 1'b1;
    #1;
    chk("rst_valid", {31'h0, isValid_out}, 0);
    chk("rst_data",  {16'h0, data_out}, 0);
    chk("rst_last",  {31'h0, isLast_out}, 0);
    chk("rst_ready", {31'h0, isReady_out}, 1);
    chk("rst_busy",  {31'h0, busy_out}, 0);
    exp_q.delete();
    fc = 0;
    mode_lat = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    mode_in = 2'd0;
    data_in = '0;
    isValid_in = 1'b0;
    isReady_in = 1'b1;
    #12;

    // 1: RELU, back-to-back, one cycle latency
    do_reset();
    cyc(1, 2'd1, {8'd7, 8'hFB}, 1);          // {-5,+7}
    cyc(1, 2'd1, {8'h80, 8'h7F}, 1);         // {+127,-128}
    chk("t1_b0", {16'h0, data_out}, 32'h0700);
    cyc(0, 2'd1, 16'h0, 1);
    chk("t1_b1", {16'h0, data_out}, 32'h007F);
    cyc(0, 2'd1, 16'h0, 1);

    // 2: LEAKY then CLIP (separate frames)
    do_reset();
    cyc(1, 2'd2, {8'hFF, 8'hF0}, 1);         // {-16,-1}
    cyc(1, 2'd2, {8'h14, 8'h80}, 1);         // {-128,+20}
    chk("t2_leak0", {16'h0, data_out}, 32'hFFFE);
    cyc(0, 2'd2, 16'h0, 1);
    chk("t2_leak1", {16'h0, data_out}, 32'h14F0);
    do_reset();
    cyc(1, 2'd3, {8'hFD, 8'h64}, 1);         // {100,-3}
    cyc(1, 2'd3, {8'h5F, 8'h60}, 1);         // {96,95}
    chk("t2_clip0", {16'h0, data_out}, 32'h0060);
    cyc(0, 2'd3, 16'h0, 1);
    chk("t2_clip1", {16'h0, data_out}, 32'h5F60);

    // 3: mode latched per frame, last tag, busy window
    do_reset();
    chk("t3_busy_idle", {31'h0, busy_out}, 0);
    cyc(1, 2'd3, {8'h78, 8'hFD}, 1);         // {-3,120}
    cyc(1, 2'd0, {8'h78, 8'hFD}, 1);
    chk("t3_busy_b1", {31'h0, busy_out}, 1);
    chk("t3_clip_b1", {16'h0, data_out}, 32'h6000);
    cyc(1, 2'd0, {8'h78, 8'hFD}, 1);
    chk("t3_nolast_b2", {31'h0, isLast_out}, 0);
    cyc(1, 2'd0, {8'h78, 8'hFD}, 1);
    chk("t3_busy_b3", {31'h0, busy_out}, 1);
    cyc(1, 2'd0, {8'h78, 8'hFD}, 1);         // beat 5, new frame, PASS
    chk("t3_busy_b4", {31'h0, busy_out}, 0);
    chk("t3_last_b4", {31'h0, isLast_out}, 1);
    chk("t3_clip_b4", {16'h0, data_out}, 32'h6000);
    cyc(0, 2'd0, 16'h0, 1);
    chk("t3_pass_b5", {16'h0, data_out}, 32'h78FD);
    chk("t3_nolast_b5", {31'h0, isLast_out}, 0);

    // 4: three stalled cycles with continuous input
    do_reset();
    cyc(1, 2'd1, 16'h1122, 1);
    cyc(1, 2'd1, 16'h33C4, 1);
    cyc(1, 2'd1, 16'hD566, 0);
    chk("t4_rdy_still", {31'h0, isReady_out}, 1);
    cyc(1, 2'd1, 16'h7788, 0);
    chk("t4_rdy_low", {31'h0, isReady_out}, 0);
    cyc(1, 2'd1, 16'h7788, 0);
    chk("t4_hold_data", {16'h0, data_out}, 32'h3300);
    cyc(1, 2'd1, 16'h7788, 1);
    cyc(1, 2'd1, 16'h99AA, 1);
    chk("t4_rdy_back", {31'h0, isReady_out}, 1);
    for (int i = 0; i < 4; i++) cyc(0, 2'd1, 16'h0, 1);
    chk("t4_drained", exp_q.size(), 0);

    // 5: reset mid-frame with outputs stalled
    do_reset();
    cyc(1, 2'd0, 16'h0102, 0);
    cyc(1, 2'd0, 16'h0304, 0);
    do_reset();
    cyc(1, 2'd2, 16'hF011, 1);
    cyc(1, 2'd2, 16'hF022, 1);
    cyc(1, 2'd2, 16'hF033, 1);
    cyc(1, 2'd2, 16'hF044, 1);
    cyc(0, 2'd2, 16'h0, 1);
    chk("t5_last4", {31'h0, isLast_out}, 1);
    chk("t5_data4", {16'h0, data_out}, 32'hFE44);
    cyc(0, 2'd2, 16'h0, 1);

    // 6: random traffic against the model
    do_reset();
    n_acc = 0;
    budget = 0;
    while (n_acc < 1000 && budget < 20000) begin
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          16'($urandom), ($urandom_range(0, 9) < 7));
      budget++;
    end
    chk("t6_budget", {31'h0, (n_acc >= 1000)}, 1);
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      cyc(0, 2'd0, 16'h0, 1);
      budget++;
    end
    chk("t6_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
